enigma_return_path: RTL

ENIGMA_RETURN_PATH -- requirements
Module: enigma_return_path

---
 rtl/enigma_return_path.sv | 124 ++++++++++++
 1 files changed

// File: rtl/enigma_return_path.sv
// Enigma return path: carries a reflected letter back through rotors I, II and III
// (inverse wiring), one rotor per cycle, with a one-deep valid/ready handshake.
module enigma_return_path (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] in_code,
    output logic       in_ready,
    input  logic [4:0] pos_l,
    input  logic [4:0] pos_m,
    input  logic [4:0] pos_r,
    output logic       out_valid,
    output logic [4:0] out_code,
    input  logic       out_ready,
    output logic       err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PASS_L = 3'd1;
    localparam logic [2:0] PASS_M = 3'd2;
    localparam logic [2:0] PASS_R = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [1:0] SEL_L = 2'd0;
    localparam logic [1:0] SEL_M = 2'd1;
    localparam logic [1:0] SEL_R = 2'd2;

    // Forward wirings (index -> letter, 0 = A); the return path searches them for the inverse.
    localparam logic [4:0] WIRE_L [26] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam logic [4:0] WIRE_M [26] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam logic [4:0] WIRE_R [26] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};

    logic [2:0] state;
    logic [4:0] code_q;
    logic [4:0] off_l;
    logic [4:0] off_m;
    logic [4:0] off_r;
    logic       err_q;
    logic       bad_input;

    function automatic logic [4:0] inverse(input logic [1:0] sel, input logic [4:0] s);
        logic [4:0] y;
        logic [4:0] w;
        y = '0;
        for (int i = 0; i < 26; i++) begin
            case (sel)
                SEL_L:   w = WIRE_L[i];
                SEL_M:   w = WIRE_M[i];
                default: w = WIRE_R[i];
            endcase
            if (w == s) y = i[4:0];
        end
        return y;
    endfunction

    // Both sums stay within 6 bits, so a single conditional subtract gives the mod-26 result.
    function automatic logic [4:0] rotor_pass(input logic [4:0] x, input logic [4:0] p,
                                              input logic [1:0] sel);
        logic [5:0] s;
        logic [5:0] d;
        logic [4:0] y;
        s = {1'b0, x} - 6'd1 + {1'b0, p};
        if (s >= 6'd26) s = s - 6'd26;
        y = inverse(sel, s[4:0]);
        d = {1'b0, y} + 6'd26 - {1'b0, p};
        if (d >= 6'd26) d = d - 6'd26;
        return d[4:0] + 5'd1;
    endfunction

    assign bad_input = (in_code == 5'd0) || (in_code > 5'd26) ||
                       (pos_l > 5'd25) || (pos_m > 5'd25) || (pos_r > 5'd25);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            code_q <= '0;
            off_l  <= '0;
            off_m  <= '0;
            off_r  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q <= in_code;
                        off_l  <= pos_l;
                        off_m  <= pos_m;
                        off_r  <= pos_r;
                        err_q  <= bad_input;
                        state  <= bad_input ? DONE : PASS_L;
                    end
                end
                PASS_L: begin
                    code_q <= rotor_pass(code_q, off_l, SEL_L);
                    state  <= PASS_M;
                end
                PASS_M: begin
                    code_q <= rotor_pass(code_q, off_m, SEL_M);
                    state  <= PASS_R;
                end
                PASS_R: begin
                    code_q <= rotor_pass(code_q, off_r, SEL_R);
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign err       = out_valid && err_q;
    assign out_code  = (out_valid && !err_q) ? code_q : 5'd0;

endmodule
